// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer for the 8-op ISA; latches its own opcode and
// drives all datapath strobes, with a data-RAM wait/timeout and illegal-op trap.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | PC increment, opcode latched
// DECODE | legality check, illegal pulse on bad opcode
// EXEC   | operand read / ALU / jump
// MEM    | data RAM access, waits on mem_ready with timeout
// WB     | register write-back or relative branch
module control_sequencer #(
  parameter int OPW         = 4,
  parameter int RAW         = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [OPW-1:0] opcode,
  input  logic           lt_flag,
  input  logic           branch_flag,
  input  logic           mem_ready,
  output logic [2:0]     state,
  output logic           pc_en,
  output logic           pc_load_abs,
  output logic           pc_branch,
  output logic           branch_dir,
  output logic [1:0]     alu_control,
  output logic           read1_en,
  output logic           read2_en,
  output logic           alt_read_sel,
  output logic           alt_write_sel,
  output logic [RAW-1:0] alt_read_addr,
  output logic [RAW-1:0] alt_write_addr,
  output logic           ext_en,
  output logic           alu_linea,
  output logic           reg_wr_en,
  output logic           mem_addr_en,
  output logic           ram_rd_en,
  output logic           ram_wr_en,
  output logic           out_en,
  output logic           busy,
  output logic           illegal,
  output logic           mem_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
    S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5
  } state_t;

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef struct packed {
    logic           pc_en, pc_load_abs, pc_branch, branch_dir;
    logic [1:0]     alu_control;
    logic           read1_en, read2_en, alt_read_sel, alt_write_sel;
    logic [RAW-1:0] alt_read_addr, alt_write_addr;
    logic           ext_en, alu_linea, reg_wr_en, mem_addr_en;
    logic           ram_rd_en, ram_wr_en, out_en, busy, illegal;
  } ctrl_t;

  state_t         state_q, state_d;
  logic [OPW-1:0] opcode_q, opcode_d;
  logic           lt_q, lt_d, dir_q, dir_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           mem_timeout;
  ctrl_t          ctrl_q;

  function automatic logic is_legal(input logic [OPW-1:0] op);
    return op[OPW-1:3] == '0;
  endfunction

  // Strobes are decoded from the next state so they leave the flops glitch-free.
  function automatic ctrl_t decode(input state_t s, input logic [OPW-1:0] op,
                                   input logic lt, input logic dir);
    ctrl_t c;
    c      = '0;
    c.busy = (s != S_IDLE);
    case (s)
      S_FETCH:  c.pc_en = 1'b1;
      S_DECODE: c.illegal = !is_legal(op);
      S_EXEC: begin
        case (op[2:0])
          3'd0: begin
            c.read1_en = 1'b1; c.alt_read_sel = 1'b1;
            c.alt_read_addr = RAW'(4); c.out_en = 1'b1;
          end
          3'd1: c.pc_load_abs = 1'b1;
          3'd2, 3'd3: begin
            c.read1_en = 1'b1; c.alt_read_sel = 1'b1; c.alt_read_addr = RAW'(2);
            c.ext_en = 1'b1; c.mem_addr_en = 1'b1;
          end
          3'd4: begin
            c.read2_en = 1'b1; c.alt_read_sel = 1'b1; c.alt_read_addr = RAW'(0);
          end
          default: begin
            c.alu_control = (op[2:0] == 3'd6) ? 2'b00 : 2'b01;
            c.read1_en = 1'b1; c.read2_en = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (op[2:0] == 3'd2) begin
          c.ram_rd_en = 1'b1;
        end else begin
          c.ram_wr_en = 1'b1; c.alt_read_sel = 1'b1;
          c.alt_read_addr = RAW'(3); c.alu_linea = 1'b1;
        end
      end
      S_WB: begin
        case (op[2:0])
          3'd2: begin
            c.alt_write_sel = 1'b1; c.alt_write_addr = RAW'(1); c.reg_wr_en = 1'b1;
          end
          3'd4: c.reg_wr_en = 1'b1;
          3'd5: begin
            c.pc_branch = lt; c.branch_dir = dir;
          end
          3'd6, 3'd7: begin
            c.alu_control = (op[2:0] == 3'd7) ? 2'b01 : 2'b00;
            c.alt_write_sel = 1'b1; c.alt_write_addr = RAW'(4); c.reg_wr_en = 1'b1;
          end
          default: c = c;
        endcase
      end
      default: c = c;
    endcase
    return c;
  endfunction

  assign mem_timeout = (state_q == S_MEM) && !mem_ready && (cnt_q == CW'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    lt_d     = lt_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH: begin
        opcode_d = opcode;
        state_d  = S_DECODE;
      end
      S_DECODE: state_d = is_legal(opcode_q) ? S_EXEC : S_FETCH;
      S_EXEC: begin
        case (opcode_q[2:0])
          3'd0, 3'd1: state_d = S_FETCH;
          3'd2, 3'd3: begin
            state_d = S_MEM;
            cnt_d   = '0;
          end
          3'd5: begin
            lt_d    = lt_flag;
            dir_d   = branch_flag;
            state_d = S_WB;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready)        state_d = (opcode_q[2:0] == 3'd2) ? S_WB : S_FETCH;
        else if (mem_timeout) state_d = S_FETCH;
        else                  cnt_d = cnt_q + CW'(1);
      end
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      lt_q     <= 1'b0;
      dir_q    <= 1'b0;
      cnt_q    <= '0;
      ctrl_q   <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      lt_q     <= lt_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      ctrl_q   <= decode(state_d, opcode_d, lt_d, dir_d);
    end
  end

  assign state          = state_q;
  assign pc_en          = ctrl_q.pc_en;
  assign pc_load_abs    = ctrl_q.pc_load_abs;
  assign pc_branch      = ctrl_q.pc_branch;
  assign branch_dir     = ctrl_q.branch_dir;
  assign alu_control    = ctrl_q.alu_control;
  assign read1_en       = ctrl_q.read1_en;
  assign read2_en       = ctrl_q.read2_en;
  assign alt_read_sel   = ctrl_q.alt_read_sel;
  assign alt_write_sel  = ctrl_q.alt_write_sel;
  assign alt_read_addr  = ctrl_q.alt_read_addr;
  assign alt_write_addr = ctrl_q.alt_write_addr;
  assign ext_en         = ctrl_q.ext_en;
  assign alu_linea      = ctrl_q.alu_linea;
  assign reg_wr_en      = ctrl_q.reg_wr_en;
  assign mem_addr_en    = ctrl_q.mem_addr_en;
  assign ram_rd_en      = ctrl_q.ram_rd_en;
  assign ram_wr_en      = ctrl_q.ram_wr_en;
  assign out_en         = ctrl_q.out_en;
  assign busy           = ctrl_q.busy;
  assign illegal        = ctrl_q.illegal;
  assign mem_err        = mem_timeout;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: expected output vectors are queued as
// each step is driven and compared against the DUT at the following negedge.
module tb_control_sequencer;

  localparam int OPW = 4;
  localparam int RAW = 5;
  localparam int MEM_TIMEOUT = 15;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [OPW-1:0] opcode = '0;
  logic           lt_flag = 1'b0, branch_flag = 1'b0, mem_ready = 1'b0;
  logic [2:0]     state;
  logic           pc_en, pc_load_abs, pc_branch, branch_dir;
  logic [1:0]     alu_control;
  logic           read1_en, read2_en, alt_read_sel, alt_write_sel;
  logic [RAW-1:0] alt_read_addr, alt_write_addr;
  logic           ext_en, alu_linea, reg_wr_en, mem_addr_en;
  logic           ram_rd_en, ram_wr_en, out_en, busy, illegal, mem_err;

  control_sequencer #(.OPW(OPW), .RAW(RAW), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clock(clock), .reset(reset), .start(start), .opcode(opcode),
    .lt_flag(lt_flag), .branch_flag(branch_flag), .mem_ready(mem_ready),
    .state(state), .pc_en(pc_en), .pc_load_abs(pc_load_abs),
    .pc_branch(pc_branch), .branch_dir(branch_dir), .alu_control(alu_control),
    .read1_en(read1_en), .read2_en(read2_en), .alt_read_sel(alt_read_sel),
    .alt_write_sel(alt_write_sel), .alt_read_addr(alt_read_addr),
    .alt_write_addr(alt_write_addr), .ext_en(ext_en), .alu_linea(alu_linea),
    .reg_wr_en(reg_wr_en), .mem_addr_en(mem_addr_en), .ram_rd_en(ram_rd_en),
    .ram_wr_en(ram_wr_en), .out_en(out_en), .busy(busy), .illegal(illegal),
    .mem_err(mem_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0]     state;
    logic           pc_en, pc_load_abs, pc_branch, branch_dir;
    logic [1:0]     alu_control;
    logic           read1_en, read2_en, alt_read_sel, alt_write_sel;
    logic [RAW-1:0] alt_read_addr, alt_write_addr;
    logic           ext_en, alu_linea, reg_wr_en, mem_addr_en;
    logic           ram_rd_en, ram_wr_en, out_en, busy, illegal, mem_err;
  } out_t;

  typedef struct {
    string tag;
    out_t  v;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2,
                         EXEC = 3'd3, MEM = 3'd4, WB = 3'd5;

  function automatic out_t observe();
    out_t o;
    o = '{state, pc_en, pc_load_abs, pc_branch, branch_dir, alu_control,
          read1_en, read2_en, alt_read_sel, alt_write_sel, alt_read_addr,
          alt_write_addr, ext_en, alu_linea, reg_wr_en, mem_addr_en,
          ram_rd_en, ram_wr_en, out_en, busy, illegal, mem_err};
    return o;
  endfunction

  // Reference table of which strobes each (state, opcode) is allowed to raise.
  function automatic out_t model(input logic [2:0] st, input int op, input logic lt,
                                 input logic dir, input logic ill, input logic me);
    out_t e;
    e = '0;
    e.state = st;
    e.busy = (st != IDLE);
    e.illegal = ill;
    e.mem_err = me;
    if (st == FETCH) e.pc_en = 1'b1;
    if (st == EXEC) begin
      if (op == 0) begin e.read1_en = 1; e.alt_read_sel = 1; e.alt_read_addr = 5'd4; e.out_en = 1; end
      if (op == 1) e.pc_load_abs = 1;
      if (op == 2 || op == 3) begin
        e.read1_en = 1; e.alt_read_sel = 1; e.alt_read_addr = 5'd2; e.ext_en = 1; e.mem_addr_en = 1;
      end
      if (op == 4) begin e.read2_en = 1; e.alt_read_sel = 1; end
      if (op == 5 || op == 7) e.alu_control = 2'b01;
      if (op >= 5) begin e.read1_en = 1; e.read2_en = 1; end
    end
    if (st == MEM) begin
      if (op == 2) e.ram_rd_en = 1;
      if (op == 3) begin e.ram_wr_en = 1; e.alt_read_sel = 1; e.alt_read_addr = 5'd3; e.alu_linea = 1; end
    end
    if (st == WB) begin
      if (op == 2) begin e.alt_write_sel = 1; e.alt_write_addr = 5'd1; e.reg_wr_en = 1; end
      if (op == 4) e.reg_wr_en = 1;
      if (op == 5) begin e.pc_branch = lt; e.branch_dir = dir; end
      if (op == 6 || op == 7) begin
        e.alu_control = (op == 7) ? 2'b01 : 2'b00;
        e.alt_write_sel = 1; e.alt_write_addr = 5'd4; e.reg_wr_en = 1;
      end
    end
    return e;
  endfunction

  task automatic compare_pop();
    exp_t e;
    out_t o;
    e = sb.pop_front();
    o = observe();
    vectors++;
    assert (o === e.v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", e.tag, o, e.v);
    end
  endtask

  // Expectation for the current cycle; checked at negedge, returns at posedge+1.
  task automatic step(input string tag, input logic [2:0] st, input int op,
                      input logic lt = 0, input logic dir = 0,
                      input logic ill = 0, input logic me = 0);
    sb.push_back('{tag, model(st, op, lt, dir, ill, me)});
    @(negedge clock);
    compare_pop();
    @(posedge clock);
    #1;
  endtask

  task automatic simple_instr(input string tag, input int op, input logic lt, input logic br);
    opcode = OPW'(op);
    step({tag, "_fetch"}, FETCH, 0);
    opcode = '0;
    step({tag, "_decode"}, DECODE, op);
    lt_flag = lt; branch_flag = br;
    step({tag, "_exec"}, EXEC, op);
    lt_flag = 0; branch_flag = 0;
    if (op >= 4) step({tag, "_wb"}, WB, op, lt, br);
  endtask

  initial begin
    #2;
    sb.push_back('{"reset_state", model(IDLE, 0, 0, 0, 0, 0)});
    compare_pop();
    @(posedge clock); #1;
    reset = 1'b0;
    step("idle_no_start", IDLE, 0);
    start = 1'b1;
    step("idle_start", IDLE, 0);

    simple_instr("add", 6, 0, 0);

    opcode = 4'd2;
    step("ldw_fetch", FETCH, 0);
    step("ldw_decode", DECODE, 2);
    step("ldw_exec", EXEC, 2);
    for (int i = 1; i <= 4; i++) begin
      mem_ready = (i == 4);
      step("ldw_mem", MEM, 2);
    end
    mem_ready = 1'b0;
    step("ldw_wb", WB, 2);

    opcode = 4'd3;
    step("stw_fetch", FETCH, 0);
    step("stw_decode", DECODE, 3);
    step("stw_exec", EXEC, 3);
    for (int i = 1; i <= MEM_TIMEOUT; i++)
      step("stw_mem_wait", MEM, 3, 0, 0, 0, (i == MEM_TIMEOUT));

    simple_instr("blt_taken", 5, 1, 0);
    simple_instr("blt_not_taken", 5, 0, 0);
    simple_instr("blt_taken_fwd", 5, 1, 1);

    opcode = 4'd9;
    step("illegal_fetch", FETCH, 0);
    step("illegal_decode", DECODE, 9, 0, 0, 1);

    simple_instr("jmp", 1, 0, 0);
    simple_instr("out", 0, 0, 0);
    simple_instr("rtr", 4, 0, 0);
    simple_instr("sub", 7, 0, 0);

    opcode = 4'd3;
    step("stw2_fetch", FETCH, 0);
    step("stw2_decode", DECODE, 3);
    step("stw2_exec", EXEC, 3);
    step("stw2_mem", MEM, 3);
    start = 1'b0;
    #2 reset = 1'b1;
    #1;
    sb.push_back('{"reset_async", model(IDLE, 0, 0, 0, 0, 0)});
    compare_pop();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) step("idle_after_reset", IDLE, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
